// File: rtl/riscv_mem_pkg.sv
// Shared constants for the unified instruction/data memory arbiter:
// owner encoding, FSM state encodings and legal parameter ranges.
package riscv_mem_pkg;

  typedef logic owner_t;

  localparam owner_t OWN_I = 1'b0;
  localparam owner_t OWN_D = 1'b1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam int MEM_LAT_MIN    = 1;
  localparam int MEM_LAT_MAX    = 15;
  localparam int STARVE_MAX_MIN = 1;
  localparam int STARVE_MAX_MAX = 15;

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// Fetch port, load/store port and memory port of the arbiter, bundled.
// slave = arbiter side, master = core/memory side.
interface riscv_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Arbitrates fetch and load/store accesses onto one single-port synchronous memory.
// state | meaning
// IDLE  | no access in flight; arbitrate and latch the winner
// ISSUE | mem_en strobe and winner's gnt
// WAIT  | count down the memory read latency, capture mem_rdata on zero
// RESP  | winner's rvalid with captured data
module riscv_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  riscv_mem_arbiter_if.slave bus
);

  if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
    $error("riscv_mem_arbiter: MEM_LAT must be in 1..15");
  end
  if (STARVE_MAX < STARVE_MAX_MIN || STARVE_MAX > STARVE_MAX_MAX) begin : g_bad_starve
    $error("riscv_mem_arbiter: STARVE_MAX must be in 1..15");
  end

  localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0]        state_q, state_d;
  owner_t            owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        lat_q, lat_d;
  logic [3:0]        starve_q, starve_d;

  logic              i_gnt_q, i_gnt_d;
  logic              d_gnt_q, d_gnt_d;
  logic              i_rvalid_q, i_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;

  logic pick_i;

  // Fetch wins when it is alone, or when data has used up its starvation budget.
  assign pick_i = bus.i_req && (!bus.d_req || starve_q == STARVE_LIM);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    lat_d    = lat_q;
    starve_d = starve_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_req || bus.d_req) begin
          state_d = ST_ISSUE;
          if (pick_i) begin
            owner_d  = OWN_I;
            we_d     = 1'b0;
            addr_d   = bus.i_addr;
            wdata_d  = '0;
            starve_d = '0;
          end else begin
            owner_d = OWN_D;
            we_d    = bus.d_we;
            addr_d  = bus.d_addr;
            wdata_d = bus.d_wdata;
            if (!bus.i_req) begin
              starve_d = '0;
            end else if (starve_q != STARVE_LIM) begin
              starve_d = starve_q + 4'd1;
            end
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        lat_d   = LAT_INIT;
      end
      ST_WAIT: begin
        if (lat_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state so that every port is a flop.
  always_comb begin
    mem_en_d   = (state_d == ST_ISSUE);
    mem_we_d   = (state_d == ST_ISSUE) && we_d;
    i_gnt_d    = (state_d == ST_ISSUE) && (owner_d == OWN_I);
    d_gnt_d    = (state_d == ST_ISSUE) && (owner_d == OWN_D);
    i_rvalid_d = (state_d == ST_RESP) && (owner_q == OWN_I);
    d_rvalid_d = (state_d == ST_RESP) && (owner_q == OWN_D);
    i_rdata_d  = i_rvalid_d ? bus.mem_rdata : '0;
    d_rdata_d  = (d_rvalid_d && !we_q) ? bus.mem_rdata : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_I;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      lat_q      <= '0;
      starve_q   <= '0;
      i_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      lat_q      <= lat_d;
      starve_q   <= starve_d;
      i_gnt_q    <= i_gnt_d;
      d_gnt_q    <= d_gnt_d;
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
    end
  end

  assign bus.i_gnt     = i_gnt_q;
  assign bus.d_gnt     = d_gnt_q;
  assign bus.i_rvalid  = i_rvalid_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench: one arbiter with MEM_LAT=1 and one with MEM_LAT=3, each
// in front of a small latency-accurate memory model.
module tb_riscv_mem_arbiter;

  logic clk = 1'b0;
  logic rst1, rst3;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  riscv_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
  riscv_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

  riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1)
  );

  riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (bus3)
  );

  // Memory models; a non-read cycle shifts in a cycle-stamped junk word so
  // that capturing mem_rdata on the wrong cycle shows up as wrong data.
  logic [31:0] mem1 [256];
  logic [31:0] pipe1;
  logic [31:0] mem3 [256];
  logic [31:0] pipe3 [3];

  always @(posedge clk) begin
    if (rst1) begin
      mem1[64] <= 32'h0000_0013;
      pipe1    <= '0;
    end else begin
      if (bus1.mem_en && bus1.mem_we) mem1[bus1.mem_addr[9:2]] <= bus1.mem_wdata;
      pipe1 <= (bus1.mem_en && !bus1.mem_we) ? mem1[bus1.mem_addr[9:2]] : (32'hBAD0_0000 | cyc);
    end
  end
  assign bus1.mem_rdata = pipe1;

  always @(posedge clk) begin
    if (rst3) begin
      mem3[16] <= 32'hCAFE_F00D;
      pipe3[0] <= '0;
      pipe3[1] <= '0;
      pipe3[2] <= '0;
    end else begin
      if (bus3.mem_en && bus3.mem_we) mem3[bus3.mem_addr[9:2]] <= bus3.mem_wdata;
      pipe3[0] <= (bus3.mem_en && !bus3.mem_we) ? mem3[bus3.mem_addr[9:2]] : (32'hBAD0_0000 | cyc);
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
    end
  end
  assign bus3.mem_rdata = pipe3[2];

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];
  logic exp_order [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_txn(input int k, input vec_t v);
    int n;
    @(posedge clk); #1;
    if (v.is_d) begin
      bus1.d_req = 1'b1; bus1.d_we = v.we; bus1.d_addr = v.addr; bus1.d_wdata = v.wdata;
    end else begin
      bus1.i_req = 1'b1; bus1.i_addr = v.addr;
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!(bus1.i_gnt || bus1.d_gnt) && n < 10);
    chk($sformatf("v%0d gnt_cycle", k), n - 1, 1);
    chk($sformatf("v%0d gnt_port", k), {bus1.i_gnt, bus1.d_gnt}, v.is_d ? 2'b01 : 2'b10);
    chk($sformatf("v%0d mem_en", k), bus1.mem_en, 1);
    chk($sformatf("v%0d mem_we", k), bus1.mem_we, v.we);
    chk($sformatf("v%0d mem_addr", k), bus1.mem_addr, v.addr);
    if (v.we) chk($sformatf("v%0d mem_wdata", k), bus1.mem_wdata, v.wdata);
    bus1.i_req = 1'b0;
    bus1.d_req = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!(bus1.i_rvalid || bus1.d_rvalid) && n < 20);
    chk($sformatf("v%0d rvalid_cycle", k), n + 1, 3);
    chk($sformatf("v%0d rvalid_port", k), {bus1.i_rvalid, bus1.d_rvalid}, v.is_d ? 2'b01 : 2'b10);
    chk($sformatf("v%0d rdata", k), v.is_d ? bus1.d_rdata : bus1.i_rdata, v.exp_rdata);
    @(negedge clk);
    chk($sformatf("v%0d rvalid_drop", k), {bus1.i_rvalid, bus1.d_rvalid, bus1.mem_en}, 0);
  endtask

  initial begin
    int n, g, last;
    logic [31:0] sampled;

    vecs[0] = '{is_d: 1'b0, we: 1'b0, addr: 32'h0000_0100, wdata: 32'h0,         exp_rdata: 32'h0000_0013};
    vecs[1] = '{is_d: 1'b1, we: 1'b1, addr: 32'h0000_2000, wdata: 32'hDEAD_BEEF, exp_rdata: 32'h0};
    vecs[2] = '{is_d: 1'b1, we: 1'b0, addr: 32'h0000_2000, wdata: 32'h0,         exp_rdata: 32'hDEAD_BEEF};
    vecs[3] = '{is_d: 1'b1, we: 1'b1, addr: 32'h0000_0044, wdata: 32'h1234_5678, exp_rdata: 32'h0};
    vecs[4] = '{is_d: 1'b0, we: 1'b0, addr: 32'h0000_0044, wdata: 32'h0,         exp_rdata: 32'h1234_5678};
    vecs[5] = '{is_d: 1'b1, we: 1'b0, addr: 32'h0000_0100, wdata: 32'h0,         exp_rdata: 32'h0000_0013};
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    rst1 = 1'b1; rst3 = 1'b1;
    bus1.i_req = 1'b0; bus1.i_addr = '0; bus1.d_req = 1'b0; bus1.d_we = 1'b0;
    bus1.d_addr = '0; bus1.d_wdata = '0;
    bus3.i_req = 1'b0; bus3.i_addr = '0; bus3.d_req = 1'b0; bus3.d_we = 1'b0;
    bus3.d_addr = '0; bus3.d_wdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ctl", {bus1.i_gnt, bus1.d_gnt, bus1.i_rvalid, bus1.d_rvalid, bus1.mem_en, bus1.mem_we}, 0);
    chk("reset mem_addr", bus1.mem_addr, 0);
    chk("reset mem_wdata", bus1.mem_wdata, 0);
    chk("reset rdata", bus1.i_rdata | bus1.d_rdata, 0);
    @(posedge clk); #1;
    rst1 = 1'b0; rst3 = 1'b0;

    for (int k = 0; k < 6; k++) run_txn(k, vecs[k]);

    // Both requesters held high: data wins until its budget is spent.
    @(posedge clk); #1;
    bus1.i_req = 1'b1; bus1.i_addr = 32'h100;
    bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 32'h44;
    g = 0; n = 0; last = 0;
    while (g < 10 && n < 100) begin
      @(negedge clk); n++;
      chk("starve no_dual_gnt", bus1.i_gnt & bus1.d_gnt, 0);
      if (bus1.i_gnt || bus1.d_gnt) begin
        chk($sformatf("starve order%0d", g), bus1.d_gnt, exp_order[g]);
        if (bus1.i_gnt) chk("starve fetch_we", bus1.mem_we, 0);
        if (g > 0) chk($sformatf("starve spacing%0d", g), n - last, 4);
        last = n;
        g++;
      end
    end
    chk("starve grants", g, 10);
    bus1.i_req = 1'b0; bus1.d_req = 1'b0;
    repeat (4) @(negedge clk);

    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("idle c%0d", k),
          {bus1.mem_en, bus1.i_gnt, bus1.d_gnt, bus1.i_rvalid, bus1.d_rvalid}, 0);
    end
    chk("idle starve_cnt", u_dut1.starve_q, 0);

    // Reset while the MEM_LAT=3 instance is waiting on memory.
    @(posedge clk); #1;
    bus3.d_req = 1'b1; bus3.d_we = 1'b0; bus3.d_addr = 32'h40;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus3.d_gnt && n < 10);
    chk("rst3 pre_gnt", bus3.d_gnt, 1);
    bus3.d_req = 1'b0;
    @(negedge clk);
    rst3 = 1'b1;
    #1;
    chk("rst3 ctl", {bus3.i_gnt, bus3.d_gnt, bus3.i_rvalid, bus3.d_rvalid, bus3.mem_en, bus3.mem_we}, 0);
    chk("rst3 data", bus3.mem_addr | bus3.mem_wdata | bus3.i_rdata | bus3.d_rdata, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rst3 quiet%0d", k), {bus3.i_rvalid, bus3.d_rvalid, bus3.mem_en, bus3.d_gnt}, 0);
    end
    @(posedge clk); #1;
    rst3 = 1'b0;

    // Normal load after reset with MEM_LAT=3.
    @(posedge clk); #1;
    bus3.d_req = 1'b1; bus3.d_we = 1'b0; bus3.d_addr = 32'h40;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus3.mem_en && n < 10);
    chk("lat3 gnt_cycle", n - 1, 1);
    chk("lat3 gnt", bus3.d_gnt, 1);
    chk("lat3 mem_addr", bus3.mem_addr, 32'h40);
    bus3.d_req = 1'b0;
    n = 0;
    sampled = '0;
    while (!bus3.d_rvalid && n < 20) begin
      @(negedge clk); n++;
      if (n == 3) sampled = bus3.mem_rdata;
    end
    chk("lat3 en_to_rvalid", n, 4);
    chk("lat3 rdata_vs_mem", bus3.d_rdata, sampled);
    chk("lat3 rdata", bus3.d_rdata, 32'hCAFE_F00D);
    chk("lat3 no_i_rvalid", bus3.i_rvalid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
Shares one single-port synchronous memory between the core's instruction-fetch port and its load/store port, so the core can run from a unified memory. Each access is a request/grant/response transaction. Requests are sequenced through a small FSM, which tolerates a configurable memory read latency. Data accesses have priority over fetches, and a starvation counter bounds how long a fetch can wait.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
MEM_LAT, 1, cycles from the mem_en cycle to valid mem_rdata; legal range 1..15, any other value is an elaboration error
STARVE_MAX, 4, consecutive data grants allowed while a fetch is pending before the fetch is forced to win; legal range 1..15

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
i_req  in  1  fetch request; held until i_gnt
i_addr  in  ADDR_W  fetch address; stable while i_req is high
i_gnt  out  1  one-cycle pulse; fetch accepted
i_rvalid  out  1  one-cycle pulse; i_rdata valid
i_rdata  out  DATA_W  fetch read data
d_req  in  1  data request; held until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_gnt  out  1  one-cycle pulse; data access accepted
d_rvalid  out  1  one-cycle pulse; load data valid or store complete
d_rdata  out  DATA_W  load data; 0 on store completion
mem_en  out  1  memory access strobe, one cycle per access
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en

Behaviour:
- All outputs are registered.
- Reset value of every output is 0. On reset the FSM is in IDLE and the starvation counter is 0.
- Reset asserted mid-transaction aborts it: no gnt or rvalid is emitted for the aborted access, and the memory sees no further mem_en.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If no request is pending, stay in IDLE.
  - Otherwise choose a winner, latch its addr, we and wdata (fetch: we=0), and go to ISSUE.
- Arbitration, evaluated in IDLE only:
  - Only d_req -> D. Only i_req -> I.
  - Both pending -> D, unless starve_cnt == STARVE_MAX, in which case I wins.
- Starvation counter:
  - Increments on each D grant while i_req is high; saturates at STARVE_MAX.
  - Clears on any I grant.
  - Clears on a D grant while i_req is low.
- ISSUE (one cycle):
  - mem_en=1; mem_we, mem_addr and mem_wdata come from the latch.
  - The winner's gnt pulses in this same cycle.
  - Next state is WAIT; latency counter is loaded with MEM_LAT-1.
- WAIT:
  - mem_en=0; the counter decrements each cycle.
  - When the counter is 0, capture mem_rdata and go to RESP.
  - With MEM_LAT=1, WAIT lasts exactly one cycle.
- RESP (one cycle):
  - The winner's rvalid pulses with the captured data. Stores return rdata=0.
  - Next state is IDLE.
- Timing:
  - Latency from a req first seen in IDLE to rvalid is MEM_LAT+2 cycles.
  - Back-to-back throughput is one access per MEM_LAT+3 cycles.
- A requester deasserting req before gnt is a protocol violation. The latched access still completes with gnt and rvalid.
- At most one gnt and one rvalid are high in any cycle. i_* and d_* pulses never overlap.
- mem_we is never 1 when the I port owns the access.
- Requests arriving while not in IDLE wait; they are evaluated on the next IDLE cycle.

Decomposition:
- Shared package riscv_mem_pkg holds:
  - owner encoding OWN_I=0, OWN_D=1;
  - FSM state encodings;
  - the MEM_LAT and STARVE_MAX legal-range limits.
- No sub-module: FSM, arbiter, counters and latch fit in one module of about 200 lines.

Test Plan:
- Single fetch, MEM_LAT=1, i_addr=0x100, memory word 0x00000013: i_gnt in cycle 1, mem_en=1 with mem_addr=0x100, i_rvalid in cycle 3 with i_rdata=0x00000013.
- Store d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF: mem_we=1 with the same addr/data during the single mem_en cycle; d_rvalid pulses with d_rdata=0; a following load from 0x2000 returns 0xDEADBEEF.
- i_req and d_req held high continuously, STARVE_MAX=4: grant order D,D,D,D,I,D,D,D,D,I; never a simultaneous gnt.
- MEM_LAT=3, load from 0x40: mem_en-to-d_rvalid spacing is 4 cycles; d_rdata equals mem_rdata as sampled 3 cycles after mem_en.
- rst asserted while in WAIT: every output is 0 on the next sampled edge with no rvalid pulse; after rst drops, the next request completes normally.
- Idle bus with no requests for 20 cycles: mem_en, all gnt and all rvalid stay 0, and the starvation counter stays 0.
